// File: rtl/i2c_bus_monitor.sv
// i2c_bus_monitor
//   Front end for the I2C peripheral controller. It synchronises and
//   glitch-filters the raw SCL/SDA pads, then detects START, repeated START
//   and STOP. It tracks bus-busy with an SCL-low abort timer and assembles
//   received bits into bytes plus the ACK bit.
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   scl_in, sda_in        raw asynchronous pad inputs
//   scl_f, sda_f          filtered lines
//   scl_rise, scl_fall    filtered SCL edge strobes
//   start_det, rstart_det START from idle / START while busy strobes
//   stop_det, timeout     STOP strobe / SCL-low abort strobe
//   bus_busy              level, high while a transfer is in progress
//   bit_valid, bit_data   strobe and value for data bits 0..7
//   byte_valid, byte_data strobe and held byte (MSB first)
//   ack_valid, ack_bit    strobe and held 9th-bit value
module i2c_bus_monitor #(
    parameter int          SYNC_STAGES    = 2,
    parameter int          FILTER_CYCLES  = 3,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_f,
    output logic       sda_f,
    output logic       scl_rise,
    output logic       scl_fall,
    output logic       start_det,
    output logic       rstart_det,
    output logic       stop_det,
    output logic       timeout,
    output logic       bus_busy,
    output logic       bit_valid,
    output logic       bit_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       ack_valid,
    output logic       ack_bit
);

    localparam logic [0:0]  ST_IDLE  = 1'b0;
    localparam logic [0:0]  ST_BUSY  = 1'b1;
    localparam logic [3:0]  FLT_LAST = 4'(FILTER_CYCLES - 1);
    localparam logic [15:0] TO_LAST  = TIMEOUT_CYCLES - 16'd1;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic       scl_f_q, scl_f_d, sda_f_q, sda_f_d;
    logic [3:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
    logic       scl_p_q, sda_p_q;
    logic [0:0] state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic [7:0] byte_q, byte_d;
    logic       ack_q, ack_d, bit_data_q, bit_data_d;
    logic [15:0] to_cnt_q, to_cnt_d;
    logic       scl_rise_q, scl_fall_q, start_q, rstart_q, stop_q, timeout_q;
    logic       bit_valid_q, byte_valid_q, ack_valid_q, busy_q;
    logic       start_d, rstart_d, stop_d, timeout_d;
    logic       bit_valid_d, byte_valid_d, ack_valid_d;
    logic       scl_s, sda_s, scl_rise_w, scl_fall_w, scl_chg_w, start_w, stop_w;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    // The filtered value flips on the FILTER_CYCLES-th consecutive disagreeing sample.
    always_comb begin
        scl_f_d   = scl_f_q;
        scl_cnt_d = '0;
        if (scl_s != scl_f_q) begin
            if (scl_cnt_q == FLT_LAST) scl_f_d = scl_s;
            else                       scl_cnt_d = scl_cnt_q + 4'd1;
        end
        sda_f_d   = sda_f_q;
        sda_cnt_d = '0;
        if (sda_s != sda_f_q) begin
            if (sda_cnt_q == FLT_LAST) sda_f_d = sda_s;
            else                       sda_cnt_d = sda_cnt_q + 4'd1;
        end
    end

    assign scl_rise_w = scl_f_q & ~scl_p_q;
    assign scl_fall_w = ~scl_f_q & scl_p_q;
    assign scl_chg_w  = scl_f_q ^ scl_p_q;
    // An SDA edge coinciding with an SCL edge is not a bus condition.
    assign start_w    = ~sda_f_q & sda_p_q & scl_f_q & ~scl_chg_w;
    assign stop_w     = sda_f_q & ~sda_p_q & scl_f_q & ~scl_chg_w;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_d       = byte_q;
        ack_d        = ack_q;
        bit_data_d   = bit_data_q;
        start_d      = 1'b0;
        rstart_d     = 1'b0;
        stop_d       = 1'b0;
        timeout_d    = 1'b0;
        bit_valid_d  = 1'b0;
        byte_valid_d = 1'b0;
        ack_valid_d  = 1'b0;
        to_cnt_d     = (state_q == ST_BUSY && !scl_f_q) ? to_cnt_q + 16'd1 : 16'd0;
        if (start_w) begin
            if (state_q == ST_IDLE) start_d  = 1'b1;
            else                    rstart_d = 1'b1;
            state_d   = ST_BUSY;
            bit_cnt_d = '0;
            shift_d   = '0;
        end else if (stop_w) begin
            stop_d    = 1'b1;
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            shift_d   = '0;
        end else if (state_q == ST_BUSY) begin
            if (TIMEOUT_CYCLES != 16'd0 && !scl_f_q && to_cnt_q == TO_LAST) begin
                // Abort drops any partial byte without a byte_valid.
                timeout_d = 1'b1;
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
                shift_d   = '0;
                to_cnt_d  = '0;
            end else if (scl_rise_w) begin
                if (bit_cnt_q == 4'd8) begin
                    ack_valid_d = 1'b1;
                    ack_d       = sda_f_q;
                    bit_cnt_d   = '0;
                end else begin
                    bit_valid_d = 1'b1;
                    bit_data_d  = sda_f_q;
                    shift_d     = {shift_q[5:0], sda_f_q};
                    bit_cnt_d   = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        byte_valid_d = 1'b1;
                        byte_d       = {shift_q, sda_f_q};
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_q   <= '1;
            sda_sync_q   <= '1;
            scl_f_q      <= 1'b1;
            sda_f_q      <= 1'b1;
            scl_cnt_q    <= '0;
            sda_cnt_q    <= '0;
            scl_p_q      <= 1'b1;
            sda_p_q      <= 1'b1;
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_q       <= '0;
            ack_q        <= 1'b1;
            bit_data_q   <= 1'b0;
            to_cnt_q     <= '0;
            scl_rise_q   <= 1'b0;
            scl_fall_q   <= 1'b0;
            start_q      <= 1'b0;
            rstart_q     <= 1'b0;
            stop_q       <= 1'b0;
            timeout_q    <= 1'b0;
            bit_valid_q  <= 1'b0;
            byte_valid_q <= 1'b0;
            ack_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            scl_sync_q   <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q   <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_f_q      <= scl_f_d;
            sda_f_q      <= sda_f_d;
            scl_cnt_q    <= scl_cnt_d;
            sda_cnt_q    <= sda_cnt_d;
            scl_p_q      <= scl_f_q;
            sda_p_q      <= sda_f_q;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_q       <= byte_d;
            ack_q        <= ack_d;
            bit_data_q   <= bit_data_d;
            to_cnt_q     <= to_cnt_d;
            scl_rise_q   <= scl_rise_w;
            scl_fall_q   <= scl_fall_w;
            start_q      <= start_d;
            rstart_q     <= rstart_d;
            stop_q       <= stop_d;
            timeout_q    <= timeout_d;
            bit_valid_q  <= bit_valid_d;
            byte_valid_q <= byte_valid_d;
            ack_valid_q  <= ack_valid_d;
            // Busy level follows the FSM one cycle after the event strobe.
            busy_q       <= (state_q == ST_BUSY);
        end
    end

    assign scl_f      = scl_f_q;
    assign sda_f      = sda_f_q;
    assign scl_rise   = scl_rise_q;
    assign scl_fall   = scl_fall_q;
    assign start_det  = start_q;
    assign rstart_det = rstart_q;
    assign stop_det   = stop_q;
    assign timeout    = timeout_q;
    assign bus_busy   = busy_q;
    assign bit_valid  = bit_valid_q;
    assign bit_data   = bit_data_q;
    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_q;
    assign ack_valid  = ack_valid_q;
    assign ack_bit    = ack_q;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// tb_i2c_bus_monitor
//   Drives I2C transactions onto the raw pins and checks the monitor's
//   strobes against a transaction-level model. The model records which
//   bits, bytes, ACKs and bus conditions each driven transaction implies.
module tb_i2c_bus_monitor;
    localparam int          SYNC = 2;
    localparam int          FILT = 3;
    localparam logic [15:0] TMO  = 16'd1000;
    localparam int          H    = 10;
    // A pin driven just after edge c is captured at c+1; filtered at c+LAT.
    localparam int          LAT  = SYNC + FILT;

    logic clk = 1'b0, reset = 1'b1, scl_in = 1'b1, sda_in = 1'b1;
    logic scl_f, sda_f, scl_rise, scl_fall, start_det, rstart_det, stop_det, timeout;
    logic bus_busy, bit_valid, bit_data, byte_valid, ack_valid, ack_bit;
    logic [7:0] byte_data;

    i2c_bus_monitor #(.SYNC_STAGES(SYNC), .FILTER_CYCLES(FILT), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .scl_in(scl_in), .sda_in(sda_in),
        .scl_f(scl_f), .sda_f(sda_f), .scl_rise(scl_rise), .scl_fall(scl_fall),
        .start_det(start_det), .rstart_det(rstart_det), .stop_det(stop_det),
        .timeout(timeout), .bus_busy(bus_busy), .bit_valid(bit_valid),
        .bit_data(bit_data), .byte_valid(byte_valid), .byte_data(byte_data),
        .ack_valid(ack_valid), .ack_bit(ack_bit)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_err = 0;

    // Observed activity
    int   start_q[$], rstart_q[$], stop_q[$], to_q[$], busy_on_q[$], busy_off_q[$];
    logic bits_q[$], acks_q[$];
    logic [7:0] bytes_q[$];
    int   n_rise, n_fall;
    logic sda_low_seen, busy_prev = 1'b0;

    // Expected activity
    logic exp_bits[$], exp_acks[$];
    logic [7:0] exp_bytes[$];
    int   e_start, e_rstart, e_stop;
    logic m_busy = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (start_det)  start_q.push_back(cyc);
            if (rstart_det) rstart_q.push_back(cyc);
            if (stop_det)   stop_q.push_back(cyc);
            if (timeout)    to_q.push_back(cyc);
            if (bit_valid)  bits_q.push_back(bit_data);
            if (byte_valid) bytes_q.push_back(byte_data);
            if (ack_valid)  acks_q.push_back(ack_bit);
            if (scl_rise)   n_rise++;
            if (scl_fall)   n_fall++;
            if (!sda_f)     sda_low_seen = 1'b1;
            if (bus_busy && !busy_prev) busy_on_q.push_back(cyc);
            if (!bus_busy && busy_prev) busy_off_q.push_back(cyc);
        end
        busy_prev = bus_busy;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        start_q.delete(); rstart_q.delete(); stop_q.delete(); to_q.delete();
        busy_on_q.delete(); busy_off_q.delete(); bits_q.delete(); acks_q.delete();
        bytes_q.delete(); exp_bits.delete(); exp_acks.delete(); exp_bytes.delete();
        n_rise = 0; n_fall = 0; sda_low_seen = 1'b0;
        e_start = 0; e_rstart = 0; e_stop = 0;
    endtask

    // Bus-level drivers; each also records what the monitor should report.
    task automatic do_start_idle();
        sda_in = 1'b0; tick(H);
        scl_in = 1'b0;
        e_start++; m_busy = 1'b1;
    endtask

    task automatic send_bit(input logic b);
        tick(3); sda_in = b; tick(H - 3);
        scl_in = 1'b1; tick(H);
        scl_in = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic a);
        for (int i = 7; i >= 0; i--) begin
            send_bit(d[i]);
            exp_bits.push_back(d[i]);
        end
        send_bit(a);
        exp_bytes.push_back(d);
        exp_acks.push_back(a);
    endtask

    // The SCL rise preceding a repeated START / STOP is sampled as a data bit.
    task automatic do_rstart();
        tick(3); sda_in = 1'b1; tick(H - 3);
        scl_in = 1'b1; tick(H);
        sda_in = 1'b0; tick(H);
        scl_in = 1'b0;
        exp_bits.push_back(1'b1); e_rstart++;
    endtask

    task automatic do_stop();
        tick(3); sda_in = 1'b0; tick(H - 3);
        scl_in = 1'b1; tick(H);
        sda_in = 1'b1; tick(H);
        if (m_busy) exp_bits.push_back(1'b0);
        e_stop++; m_busy = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; scl_in = 1'b1; sda_in = 1'b1;
        tick(3);
        n_cmp++;
        if ({scl_f, sda_f, bus_busy, byte_data, ack_bit} !== {1'b1, 1'b1, 1'b0, 8'h00, 1'b1}) begin
            n_err++;
            $display("FAIL reset_values: got scl_f=%b sda_f=%b busy=%b byte=%h ack=%b, want 1 1 0 00 1",
                     scl_f, sda_f, bus_busy, byte_data, ack_bit);
        end
        n_cmp++;
        if ({scl_rise, scl_fall, start_det, rstart_det, stop_det, timeout, bit_valid, byte_valid, ack_valid} !== 9'b0) begin
            n_err++;
            $display("FAIL reset_pulses: got %b want 000000000",
                     {scl_rise, scl_fall, start_det, rstart_det, stop_det, timeout, bit_valid, byte_valid, ack_valid});
        end
        reset = 1'b0;
        clear_all();
        tick(100);
        n_cmp++;
        if (start_q.size() + rstart_q.size() + stop_q.size() + to_q.size() + bits_q.size() + n_rise + n_fall != 0) begin
            n_err++;
            $display("FAIL idle_no_events: got %0d events want 0",
                     start_q.size() + rstart_q.size() + stop_q.size() + to_q.size() + bits_q.size() + n_rise + n_fall);
        end
        n_cmp++;
        if (bus_busy !== 1'b0) begin
            n_err++; $display("FAIL idle_busy: got %b want 0", bus_busy);
        end
    endtask

    task automatic test_start();
        int c;
        clear_all();
        c = cyc;
        do_start_idle();
        n_cmp++;
        if (start_q.size() != 1 || start_q[0] != c + LAT + 1) begin
            n_err++;
            $display("FAIL start_timing: got count=%0d cyc=%0d want 1 at %0d",
                     start_q.size(), (start_q.size() > 0) ? start_q[0] - c : -1, LAT + 1);
        end
        n_cmp++;
        if (busy_on_q.size() != 1 || start_q.size() != 1 || busy_on_q[0] != start_q[0] + 1) begin
            n_err++;
            $display("FAIL busy_after_start: got %0d busy edges want busy the cycle after start_det",
                     busy_on_q.size());
        end
    endtask

    task automatic test_byte();
        logic [7:0] d;
        logic a;
        send_byte(8'hA5, 1'b0);
        for (int k = 0; k < 2; k++) begin
            d = 8'($urandom);
            a = 1'($urandom);
            send_byte(d, a);
        end
        tick(H);
        n_cmp++;
        if (bits_q.size() != exp_bits.size()) begin
            n_err++; $display("FAIL bit_count: got %0d want %0d", bits_q.size(), exp_bits.size());
        end else begin
            for (int i = 0; i < exp_bits.size(); i++) begin
                n_cmp++;
                if (bits_q[i] !== exp_bits[i]) begin
                    n_err++; $display("FAIL bit_value[%0d]: got %b want %b", i, bits_q[i], exp_bits[i]);
                end
            end
        end
        n_cmp++;
        if (bytes_q.size() != 3 || bytes_q[0] !== 8'hA5 || bytes_q[1] !== exp_bytes[1] || bytes_q[2] !== exp_bytes[2]) begin
            n_err++;
            $display("FAIL bytes: got count=%0d first=%h want 3 starting a5", bytes_q.size(),
                     (bytes_q.size() > 0) ? bytes_q[0] : 8'hxx);
        end
        n_cmp++;
        if (acks_q.size() != 3 || acks_q[0] !== 1'b0 || acks_q[1] !== exp_acks[1] || acks_q[2] !== exp_acks[2]) begin
            n_err++; $display("FAIL acks: got count=%0d want 3 matching model", acks_q.size());
        end
        n_cmp++;
        if (byte_data !== exp_bytes[2] || ack_bit !== exp_acks[2]) begin
            n_err++;
            $display("FAIL held_values: got %h/%b want %h/%b", byte_data, ack_bit, exp_bytes[2], exp_acks[2]);
        end
    endtask

    task automatic test_rstart_stop();
        clear_all();
        do_rstart();
        send_byte(8'($urandom), 1'b0);
        do_stop();
        n_cmp++;
        if (rstart_q.size() != e_rstart || start_q.size() != 0 || stop_q.size() != e_stop) begin
            n_err++;
            $display("FAIL rstart_stop_counts: got rs=%0d s=%0d p=%0d want %0d 0 %0d",
                     rstart_q.size(), start_q.size(), stop_q.size(), e_rstart, e_stop);
        end
        n_cmp++;
        if (busy_off_q.size() != 1 || stop_q.size() != 1 || busy_off_q[0] != stop_q[0] + 1) begin
            n_err++; $display("FAIL busy_after_stop: got %0d busy drops want one, cycle after stop_det",
                              busy_off_q.size());
        end
        n_cmp++;
        if (bytes_q.size() != 1 || bytes_q[0] !== exp_bytes[0] || bits_q.size() != exp_bits.size()) begin
            n_err++; $display("FAIL rstart_byte: got %0d bytes %0d bits want 1 and %0d",
                              bytes_q.size(), bits_q.size(), exp_bits.size());
        end
    endtask

    task automatic test_glitch();
        clear_all();
        sda_in = 1'b0; tick(FILT - 1); sda_in = 1'b1; tick(20);
        scl_in = 1'b0; tick(FILT - 1); scl_in = 1'b1; tick(20);
        n_cmp++;
        if (sda_low_seen !== 1'b0 || n_fall != 0 || start_q.size() + stop_q.size() != 0) begin
            n_err++; $display("FAIL short_glitch: got sda_low=%b falls=%0d conds=%0d want 0 0 0",
                              sda_low_seen, n_fall, start_q.size() + stop_q.size());
        end
        // A pulse exactly FILTER_CYCLES long does pass: START then STOP.
        sda_in = 1'b0; tick(FILT); sda_in = 1'b1; tick(20);
        n_cmp++;
        if (sda_low_seen !== 1'b1 || start_q.size() != 1 || stop_q.size() != 1) begin
            n_err++; $display("FAIL filter_edge: got sda_low=%b start=%0d stop=%0d want 1 1 1",
                              sda_low_seen, start_q.size(), stop_q.size());
        end
        clear_all();
        sda_in = 1'b0; scl_in = 1'b0; tick(H);
        sda_in = 1'b1; scl_in = 1'b1; tick(H);
        n_cmp++;
        if (start_q.size() + stop_q.size() != 0 || n_fall != 1 || n_rise != 1 || bus_busy !== 1'b0) begin
            n_err++; $display("FAIL simultaneous_edges: got conds=%0d fall=%0d rise=%0d busy=%b want 0 1 1 0",
                              start_q.size() + stop_q.size(), n_fall, n_rise, bus_busy);
        end
    endtask

    task automatic test_timeout();
        int c;
        clear_all();
        do_start_idle();
        for (int i = 0; i < 3; i++) begin
            logic b;
            b = 1'($urandom);
            send_bit(b);
            exp_bits.push_back(b);
        end
        c = cyc;
        tick(int'(TMO) + LAT + 20);
        m_busy = 1'b0;
        n_cmp++;
        if (to_q.size() != 1 || to_q[0] != c + LAT + int'(TMO)) begin
            n_err++; $display("FAIL timeout_pulse: got count=%0d at=%0d want 1 at %0d",
                              to_q.size(), (to_q.size() > 0) ? to_q[0] - c : -1, LAT + int'(TMO));
        end
        n_cmp++;
        if (bus_busy !== 1'b0 || bytes_q.size() != 0 || bits_q.size() != exp_bits.size()) begin
            n_err++; $display("FAIL timeout_state: got busy=%b bytes=%0d bits=%0d want 0 0 %0d",
                              bus_busy, bytes_q.size(), bits_q.size(), exp_bits.size());
        end
        sda_in = 1'b1; tick(H); scl_in = 1'b1; tick(H);
        clear_all();
        do_start_idle();
        send_byte(8'($urandom), 1'b1);
        do_stop();
        n_cmp++;
        if (start_q.size() != 1 || rstart_q.size() != 0 || bytes_q.size() != 1 || bytes_q[0] !== exp_bytes[0]) begin
            n_err++; $display("FAIL after_timeout: got start=%0d rstart=%0d bytes=%0d want 1 0 1",
                              start_q.size(), rstart_q.size(), bytes_q.size());
        end
    endtask

    task automatic test_reset_mid();
        clear_all();
        do_start_idle();
        for (int i = 0; i < 4; i++) send_bit(1'($urandom));
        sda_in = 1'b1; tick(3);
        reset = 1'b1; tick(1);
        n_cmp++;
        if ({bus_busy, byte_data, ack_bit, scl_f, sda_f, bit_valid} !== {1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL mid_reset: got busy=%b byte=%h ack=%b scl_f=%b sda_f=%b bv=%b want 0 00 1 1 1 0",
                              bus_busy, byte_data, ack_bit, scl_f, sda_f, bit_valid);
        end
        reset = 1'b0; m_busy = 1'b0;
        tick(H); scl_in = 1'b1; tick(H);
        clear_all();
        do_start_idle();
        send_byte(8'($urandom), 1'b0);
        do_stop();
        n_cmp++;
        if (bytes_q.size() != 1 || bytes_q[0] !== exp_bytes[0] || bits_q.size() != exp_bits.size()) begin
            n_err++; $display("FAIL post_reset_byte: got %0d bytes %0d bits want 1 and %0d",
                              bytes_q.size(), bits_q.size(), exp_bits.size());
        end
    endtask

    task automatic test_back_to_back();
        clear_all();
        for (int t = 0; t < 3; t++) begin
            do_start_idle();
            for (int k = 0; k < 1 + int'($urandom_range(1)); k++) send_byte(8'($urandom), 1'($urandom));
            if ($urandom_range(1) == 1) begin
                do_rstart();
                send_byte(8'($urandom), 1'($urandom));
            end
            do_stop();
        end
        n_cmp++;
        if (start_q.size() != e_start || rstart_q.size() != e_rstart || stop_q.size() != e_stop) begin
            n_err++; $display("FAIL b2b_conditions: got %0d/%0d/%0d want %0d/%0d/%0d",
                              start_q.size(), rstart_q.size(), stop_q.size(), e_start, e_rstart, e_stop);
        end
        n_cmp++;
        if (bytes_q.size() != exp_bytes.size() || bits_q.size() != exp_bits.size()) begin
            n_err++; $display("FAIL b2b_counts: got %0d bytes %0d bits want %0d %0d",
                              bytes_q.size(), bits_q.size(), exp_bytes.size(), exp_bits.size());
        end else begin
            for (int i = 0; i < exp_bytes.size(); i++) begin
                n_cmp++;
                if (bytes_q[i] !== exp_bytes[i] || acks_q[i] !== exp_acks[i]) begin
                    n_err++; $display("FAIL b2b_byte[%0d]: got %h/%b want %h/%b",
                                      i, bytes_q[i], acks_q[i], exp_bytes[i], exp_acks[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_byte();
        test_rstart_stop();
        test_glitch();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_bus_monitor.md
# i2c_bus_monitor

Parametrised I2C bus front end that oversamples raw SCL/SDA on the system clock and synchronises and glitch-filters both lines. It detects START, repeated START and STOP, and tracks bus-busy state with an SCL-low timeout. It assembles received bits into bytes plus ACK. It sits between the pads and the I2C peripheral controller, replacing the earlier start-only detector, and supplies one-cycle event strobes the controller consumes directly.

## Interface
- SYNC_STAGES, 2, synchroniser flops per line; legal range ≥2.
- FILTER_CYCLES, 3, consecutive agreeing samples needed before a filtered line changes; legal range 1..15.
- TIMEOUT_CYCLES, 16'd1000, clk cycles SCL may stay low while busy before abort; 0 disables.
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high.
- scl_in  input  1  raw SCL pin, asynchronous.
- sda_in  input  1  raw SDA pin, asynchronous.
- scl_f  output  1  filtered SCL.
- sda_f  output  1  filtered SDA.
- scl_rise  output  1  one-cycle pulse on a filtered SCL 0→1.
- scl_fall  output  1  one-cycle pulse on a filtered SCL 1→0.
- start_det  output  1  one-cycle pulse on START from IDLE.
- rstart_det  output  1  one-cycle pulse on START while BUSY.
- stop_det  output  1  one-cycle pulse on STOP.
- timeout  output  1  one-cycle pulse on SCL-low timeout.
- bus_busy  output  1  high in BUSY state.
- bit_valid  output  1  one-cycle pulse on each sampled data bit, positions 0..7.
- bit_data  output  1  value of the bit flagged by bit_valid.
- byte_valid  output  1  one-cycle pulse after the 8th bit.
- byte_data  output  8  assembled byte, MSB first; held until the next byte_valid.
- ack_valid  output  1  one-cycle pulse on the 9th bit.
- ack_bit  output  1  9th-bit value (0 = ACK); held.

## Operation
- Synchroniser: per-line shift chain of SYNC_STAGES flops. Reset value is 1, matching the idle bus.
- Filter: per-line counter.
  - While the synchronised value differs from the filtered value, the counter increments.
  - When it reaches FILTER_CYCLES, the filtered value takes the synchronised value and the counter clears.
  - Any cycle where the two match clears the counter.
  - Pulses shorter than FILTER_CYCLES samples never reach scl_f/sda_f.
- Edge detection compares the filtered values with their one-cycle-delayed copies.
- Conditions are evaluated on filtered edges only:
  - START: sda_f falls while scl_f is high and scl_f is unchanged this cycle.
  - STOP: sda_f rises while scl_f is high and scl_f is unchanged this cycle.
  - If sda_f and scl_f change in the same cycle, the SDA edge produces no START/STOP. Only the SCL edge is reported.
- FSM has two states:
  - IDLE → BUSY on START; emits start_det and clears bit_cnt and the shift register.
  - BUSY → BUSY on START; emits rstart_det and clears bit_cnt and the shift register.
  - BUSY → IDLE on STOP (stop_det) or on timeout (timeout).
  - STOP while IDLE emits stop_det with no state change.
- Bit assembly, BUSY only, on scl_rise:
  - bit_cnt 0..7: shift sda_f in at the LSB, pulse bit_valid with bit_data = sda_f, increment bit_cnt.
  - After bit_cnt 7: load byte_data from the shifted value and pulse byte_valid in the same cycle as the 8th bit_valid.
  - bit_cnt 8: pulse ack_valid with ack_bit = sda_f, no bit_valid, wrap bit_cnt to 0.
  - scl_rise in IDLE is reported on scl_rise only; no assembly.
- Timeout:
  - A counter runs while BUSY and scl_f = 0. It clears on scl_f = 1 or in IDLE.
  - At TIMEOUT_CYCLES it pulses timeout, enters IDLE and clears bit_cnt.
  - Partial bytes are discarded; byte_valid is not pulsed.
- Reset values:
  - scl_f = sda_f = 1.
  - All pulses = 0, bus_busy = 0, byte_data = 0, ack_bit = 1.
  - bit_cnt = 0, counters = 0, FSM in IDLE.
  - Releasing reset on an idle-high bus produces no event.

## Timing
- A pin change stable from clk edge k appears on scl_f/sda_f at edge k+SYNC_STAGES+FILTER_CYCLES−1. That is 4 cycles for defaults.
- All event pulses are registered and assert one cycle after the filtered change, each exactly one cycle wide.
- byte_data/ack_bit update in the same cycle as their valid strobe.
- Minimum SCL high/low and SDA setup, in clk cycles, must exceed FILTER_CYCLES+1 for correct detection. Violations are filtered, not flagged.
- Reset mid-transfer takes effect on the next edge. All outputs reach reset values in that cycle; in-flight bytes are dropped.

## Test plan
- Idle bus across reset release, both lines held 1 → no pulse for 100 cycles; bus_busy = 0.
- SDA 1→0 with SCL = 1, then SCL low → start_det exactly once, 5 cycles after the SDA change (defaults); bus_busy = 1 from the next cycle.
- Send byte 0xA5 then ACK = 0, SCL half-period 10 cycles → 8 bit_valid pulses 1,0,1,0,0,1,0,1; byte_valid with byte_data = 0xA5; ack_valid with ack_bit = 0; bit_cnt back to 0.
- Second START mid-session, then STOP → rstart_det, then stop_det; bus_busy drops the cycle after stop_det; no start_det.
- 2-cycle SDA glitch while SCL high (FILTER_CYCLES = 3) → sda_f unchanged; no start/stop pulses.
- BUSY with SCL held low 1000 cycles (TIMEOUT_CYCLES = 1000) → single timeout pulse; bus_busy = 0; the next START gives start_det, not rstart_det.
